// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 constants for the VGA raster timing generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_SYNC = 2'd0,
    PH_BP   = 2'd1,
    PH_ACT  = 2'd2,
    PH_FP   = 2'd3
  } phase_e;

  // Per-pixel video flags carried through the read-latency alignment pipeline.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic act;
    logic win;
    logic fstart;
    logic lstart;
  } video_flags_t;

  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_H_ACT  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam int DEF_V_ACT  = 480;
  localparam int DEF_V_FP   = 10;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus its SYNC/BP/ACT/FP phase, both advanced by step.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC = DEF_H_SYNC,
  parameter int BP   = DEF_H_BP,
  parameter int ACT  = DEF_H_ACT,
  parameter int FP   = DEF_H_FP,
  parameter int CW   = 10
) (
  input  logic          clk_25mhz,
  input  logic          rst_n,
  input  logic          step,
  output logic [CW-1:0] count,
  output phase_e        phase,
  output logic          wrap
);

  localparam int TOT = SYNC + BP + ACT + FP;

  phase_e phase_d;

  assign wrap = step && (count == CW'(TOT - 1));

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PH_SYNC;
    end else begin
      phase <= phase_d;
    end
  end

  // Phase changes on the step that leaves the last count of the current phase.
  always_comb begin
    phase_d = phase;
    if (step) begin
      if (count == CW'(TOT - 1)) begin
        phase_d = PH_SYNC;
      end else if (count == CW'(SYNC - 1)) begin
        phase_d = PH_BP;
      end else if (count == CW'(SYNC + BP - 1)) begin
        phase_d = PH_ACT;
      end else if (count == CW'(SYNC + BP + ACT - 1)) begin
        phase_d = PH_FP;
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing: syncs, active/window enables and a replicated framebuffer
// read address, with the video flags delayed to line up with RAM read data.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int H_ACT       = DEF_H_ACT,
  parameter int H_FP        = DEF_H_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int V_ACT       = DEF_V_ACT,
  parameter int V_FP        = DEF_V_FP,
  parameter int SYNC_POL    = 0,
  parameter int WIN_W       = 400,
  parameter int WIN_H       = 328,
  parameter int SCALE_SHIFT = 1,
  parameter int AW          = 16,
  parameter int RD_LAT      = 1
) (
  input  logic          clk_25mhz,
  input  logic          rst_n,
  input  logic          en,
  input  logic [9:0]    win_x0,
  input  logic [9:0]    win_y0,
  output logic          htb_en,
  output logic          ltb_en,
  output logic          xs_en,
  output logic          xs_t_en,
  output logic [9:0]    cnt_h,
  output logic [9:0]    cnt_l,
  output logic [AW-1:0] rd_addr,
  output logic          frame_start,
  output logic          line_start
);

  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam logic SYNC_ON = (SYNC_POL != 0);
  localparam video_flags_t FLAGS_RST = '{hsync: ~SYNC_ON, vsync: ~SYNC_ON, act: 1'b0,
                                         win: 1'b0, fstart: 1'b0, lstart: 1'b0};
  localparam int SW = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
  localparam logic [SW-1:0] SUB_MAX = SW'((1 << SCALE_SHIFT) - 1);
  localparam logic [AW-1:0] ROW_W = AW'(WIN_W >> SCALE_SHIFT);

  phase_e       h_phase;
  phase_e       v_phase;
  logic         h_wrap;
  logic         v_wrap;
  logic         at_origin;
  logic [9:0]   wx0_q;
  logic [9:0]   wy0_q;
  logic [11:0]  hx;
  logic [11:0]  vy;
  logic [11:0]  x_end;
  logic [11:0]  y_end;
  logic [11:0]  x_lim;
  logic         act_h;
  logic         act_v;
  logic         in_win;
  logic         x_last;
  logic [AW-1:0] line_base;
  logic [AW-1:0] x_cnt;
  logic [SW-1:0] x_sub;
  logic [SW-1:0] y_sub;
  video_flags_t flags_d;
  video_flags_t pipe [RD_LAT+1];

  vga_axis_counter #(
    .SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP), .CW(10)
  ) u_h_axis (
    .clk_25mhz(clk_25mhz), .rst_n(rst_n), .step(en),
    .count(cnt_h), .phase(h_phase), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP), .CW(10)
  ) u_v_axis (
    .clk_25mhz(clk_25mhz), .rst_n(rst_n), .step(h_wrap),
    .count(cnt_l), .phase(v_phase), .wrap(v_wrap)
  );

  // at_origin marks raster position (0,0); it survives en = 0 because it only moves on steps.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      at_origin <= 1'b1;
      wx0_q     <= '0;
      wy0_q     <= '0;
    end else if (en) begin
      at_origin <= v_wrap;
      if (at_origin) begin
        wx0_q <= win_x0;
        wy0_q <= win_y0;
      end
    end
  end

  assign act_h  = (h_phase == PH_ACT);
  assign act_v  = (v_phase == PH_ACT);
  assign hx     = {2'b00, cnt_h} - 12'(H_START);
  assign vy     = {2'b00, cnt_l} - 12'(V_START);
  assign x_end  = {2'b00, wx0_q} + 12'(WIN_W);
  assign y_end  = {2'b00, wy0_q} + 12'(WIN_H);
  assign x_lim  = (x_end > 12'(H_ACT)) ? 12'(H_ACT) : x_end;
  assign in_win = act_h && act_v && (hx >= {2'b00, wx0_q}) && (hx < x_end)
                  && (vy >= {2'b00, wy0_q}) && (vy < y_end);
  assign x_last = (hx == x_lim - 12'd1);

  // Address of the pixel at the current position is registered, so it appears one clock later.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr   <= '0;
      line_base <= '0;
      x_cnt     <= '0;
      x_sub     <= '0;
      y_sub     <= '0;
    end else if (en) begin
      if (at_origin) begin
        line_base <= '0;
        x_cnt     <= '0;
        x_sub     <= '0;
        y_sub     <= '0;
      end else if (in_win) begin
        rd_addr <= line_base + x_cnt;
        if (x_last) begin
          x_cnt <= '0;
          x_sub <= '0;
          if (y_sub == SUB_MAX) begin
            y_sub     <= '0;
            line_base <= line_base + ROW_W;
          end else begin
            y_sub <= y_sub + 1'b1;
          end
        end else if (x_sub == SUB_MAX) begin
          x_sub <= '0;
          x_cnt <= x_cnt + 1'b1;
        end else begin
          x_sub <= x_sub + 1'b1;
        end
      end
    end
  end

  always_comb begin
    flags_d = FLAGS_RST;
    if (en) begin
      flags_d.hsync  = (h_phase == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
      flags_d.vsync  = (v_phase == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
      flags_d.act    = act_h && act_v;
      flags_d.win    = in_win;
      flags_d.fstart = at_origin;
      flags_d.lstart = (cnt_h == 10'd0);
    end
  end

  // Stage 0 lines up with rd_addr; RD_LAT more stages line up with the RAM read data.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= RD_LAT; i++) pipe[i] <= FLAGS_RST;
    end else begin
      pipe[0] <= flags_d;
      for (int i = 1; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign htb_en      = pipe[RD_LAT].hsync;
  assign ltb_en      = pipe[RD_LAT].vsync;
  assign xs_en       = pipe[RD_LAT].act;
  assign xs_t_en     = pipe[RD_LAT].win;
  assign frame_start = pipe[RD_LAT].fstart;
  assign line_start  = pipe[RD_LAT].lstart;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a scaled-down raster: frame-tick reference model, RAM model,
// randomized enable/window stimulus, directed pause and reset scenarios.
module tb_vga_timing_gen;

  localparam int H_SYNC = 8,  H_BP = 6, H_ACT = 40, H_FP = 4;
  localparam int V_SYNC = 2,  V_BP = 3, V_ACT = 20, V_FP = 2;
  localparam int SYNC_POL = 0;
  localparam int WIN_W = 16, WIN_H = 12, S = 1, AW = 16, LAT = 3;
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int ROW_W = WIN_W >> S;
  localparam int LAST_ADDR = ROW_W * (WIN_H >> S) - 1;
  localparam bit SYNC_ON = (SYNC_POL != 0);
  localparam int EW = 7 + AW;

  logic          clk_25mhz;
  logic          rst_n;
  logic          en;
  logic [9:0]    win_x0;
  logic [9:0]    win_y0;
  logic          htb_en, ltb_en, xs_en, xs_t_en, frame_start, line_start;
  logic [9:0]    cnt_h, cnt_l;
  logic [AW-1:0] rd_addr;

  vga_timing_gen #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
    .SYNC_POL(SYNC_POL), .WIN_W(WIN_W), .WIN_H(WIN_H), .SCALE_SHIFT(S),
    .AW(AW), .RD_LAT(LAT)
  ) dut (
    .clk_25mhz(clk_25mhz), .rst_n(rst_n), .en(en), .win_x0(win_x0), .win_y0(win_y0),
    .htb_en(htb_en), .ltb_en(ltb_en), .xs_en(xs_en), .xs_t_en(xs_t_en),
    .cnt_h(cnt_h), .cnt_l(cnt_l), .rd_addr(rd_addr),
    .frame_start(frame_start), .line_start(line_start)
  );

  // clock / reset
  initial clk_25mhz = 1'b0;
  always #20 clk_25mhz = ~clk_25mhz;

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] ram_q[$];
  logic [AW-1:0] ram_data;
  logic [AW-1:0] m_addr;
  logic [9:0]    m_wx0, m_wy0;
  int mp;
  int f_en, f_act, f_win, f_lmax, f_amax, l_run;
  int last_win, last_lmax, last_amax, frames_done;
  int rel_cyc;
  bit fs_seen, rst_armed;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs for frame tick p: {en, hsync, vsync, act, win, fstart, lstart, addr}.
  function automatic logic [EW-1:0] model_entry(input int p, input logic e,
                                                input logic [9:0] wx0, input logic [9:0] wy0);
    int h, l, ax, ay, wx, wy, addr;
    bit act, win, hs, vs;
    h    = p % H_TOT;
    l    = p / H_TOT;
    ax   = h - H_START;
    ay   = l - V_START;
    wx   = ax - int'(wx0);
    wy   = ay - int'(wy0);
    act  = e && ax >= 0 && ax < H_ACT && ay >= 0 && ay < V_ACT;
    win  = act && wx >= 0 && wx < WIN_W && wy >= 0 && wy < WIN_H;
    hs   = (e && h < H_SYNC) ? SYNC_ON : !SYNC_ON;
    vs   = (e && l < V_SYNC) ? SYNC_ON : !SYNC_ON;
    addr = win ? (wy >> S) * ROW_W + (wx >> S) : 0;
    return {e, hs, vs, act, win, e && p == 0, e && h == 0, AW'(addr)};
  endfunction

  task automatic model_reset();
    mp = 0;
    m_wx0 = '0;
    m_wy0 = '0;
    m_addr = '0;
    exp_q.delete();
    ram_q.delete();
    for (int i = 0; i <= LAT; i++) exp_q.push_back({1'b0, !SYNC_ON, !SYNC_ON, 4'b0000, AW'(0)});
    fs_seen = 0;
    rst_armed = 1;
    rel_cyc = 0;
  endtask

  // scoreboard: compare at the falling edge, then advance the model by one clock
  always @(negedge clk_25mhz) begin
    logic [EW-1:0] cur, out_e;
    if (!rst_n) begin
      model_reset();
    end else begin
      check_val("cnt_h", cnt_h, mp % H_TOT);
      check_val("cnt_l", cnt_l, mp / H_TOT);
      check_val("rd_addr", rd_addr, m_addr);
      out_e = exp_q.pop_front();
      check_val("flags", {htb_en, ltb_en, xs_en, xs_t_en, frame_start, line_start},
                out_e[EW-2:AW]);
      ram_q.push_back(rd_addr);
      if (ram_q.size() > LAT) ram_data = ram_q.pop_front();
      if (xs_t_en === 1'b1) check_val("ram_data", ram_data, out_e[AW-1:0]);

      if (frame_start === 1'b1) begin
        if (rst_armed) begin
          check_val("fs_after_rst", rel_cyc, LAT + 1);
          rst_armed = 0;
        end
        if (fs_seen) begin
          check_val("frame_clocks", f_en, FRAME);
          check_val("frame_act", f_act, H_ACT * V_ACT);
          last_win = f_win;
          last_lmax = f_lmax;
          last_amax = f_amax;
          frames_done++;
        end
        fs_seen = 1;
        f_en = 0; f_act = 0; f_win = 0; f_lmax = 0; f_amax = 0;
      end
      if (line_start === 1'b1) l_run = 0;
      if (out_e[EW-1]) f_en++;
      if (xs_en === 1'b1) f_act++;
      if (xs_t_en === 1'b1) begin
        f_win++;
        l_run++;
        if (l_run > f_lmax) f_lmax = l_run;
        if (int'(ram_data) > f_amax) f_amax = int'(ram_data);
      end

      cur = model_entry(mp, en, m_wx0, m_wy0);
      exp_q.push_back(cur);
      if (cur[AW+2]) m_addr = cur[AW-1:0];
      if (en) begin
        if (mp == 0) begin
          m_wx0 = win_x0;
          m_wy0 = win_y0;
        end
        mp = (mp + 1) % FRAME;
      end
      rel_cyc++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_pos(input int h, input int l);
    int n;
    n = 0;
    while (!(cnt_h == 10'(h) && cnt_l == 10'(l)) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    check_val("wait_pos_timeout", n < 2 * FRAME, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_hsync"}, htb_en, !SYNC_ON);
    check_val({tag, "_vsync"}, ltb_en, !SYNC_ON);
    check_val({tag, "_act"}, xs_en, 0);
    check_val({tag, "_win"}, xs_t_en, 0);
    check_val({tag, "_fstart"}, frame_start, 0);
    check_val({tag, "_lstart"}, line_start, 0);
    check_val({tag, "_cnt_h"}, cnt_h, 0);
    check_val({tag, "_cnt_l"}, cnt_l, 0);
    check_val({tag, "_addr"}, rd_addr, 0);
  endtask

  initial begin
    int hold_h, hold_l, fd0;
    f_en = 0; f_act = 0; f_win = 0; f_lmax = 0; f_amax = 0; l_run = 0;
    last_win = 0; last_lmax = 0; last_amax = 0; frames_done = 0;
    ram_data = '0;
    rst_n = 1'b0;
    en = 1'b1;
    win_x0 = '0;
    win_y0 = '0;
    run(3);
    check_reset_outputs("rst_init");
    rst_n = 1'b1;

    // full-window raster with origin window
    run(2 * FRAME + 100);
    check_val("frames_done", frames_done, 2);
    check_val("win_pixels", last_win, WIN_W * WIN_H);
    check_val("win_line_len", last_lmax, WIN_W);
    check_val("last_addr", last_amax, LAST_ADDR);

    // clipped window, changed mid-frame
    win_x0 = 10'd30;
    win_y0 = 10'd4;
    run(2 * FRAME + 100);
    check_val("clip_pixels", last_win, (H_ACT - 30) * WIN_H);
    check_val("clip_line_len", last_lmax, H_ACT - 30);

    // enable pause mid-line
    win_x0 = 10'd5;
    win_y0 = 10'd2;
    wait_pos(H_START + 10, V_START + 5);
    en = 1'b0;
    hold_h = mp % H_TOT;
    hold_l = mp / H_TOT;
    fd0 = frames_done;
    run(1000);
    check_val("pause_cnt_h", cnt_h, hold_h);
    check_val("pause_cnt_l", cnt_l, hold_l);
    check_val("pause_act", xs_en, 0);
    check_val("pause_hsync", htb_en, !SYNC_ON);
    check_val("pause_vsync", ltb_en, !SYNC_ON);
    en = 1'b1;
    run(2 * FRAME + 100);
    check_val("frames_after_pause", frames_done >= fd0 + 2, 1);

    // randomized enable gaps and window moves
    for (int i = 0; i < 8000; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 499) == 0) begin
        win_x0 = 10'($urandom_range(0, 45));
        win_y0 = 10'($urandom_range(0, 25));
      end
      tick();
    end
    en = 1'b1;
    win_x0 = '0;
    win_y0 = '0;
    run(FRAME + 50);

    // asynchronous reset inside the window
    wait_pos(H_START + 5, V_START + 3);
    #5;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    run(2);
    rst_n = 1'b1;
    run(FRAME + 200);
    check_val("rst_fs_seen", fs_seen, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
